// File: rtl/msdft_pkg.sv
// Shared definitions for the MSDFT run-time sequencer and core.
package msdft_pkg;

  // Sliding-DFT window length; must match the core delay line depth.
  localparam int unsigned DftLenDefault = 64;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StFill,
    StInteg,
    StWaitRes,
    StHold
  } msdft_seq_state_t;

endpackage

// File: rtl/msdft_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module msdft_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/msdft_sequencer.sv
// Run-time sequencer for the MSDFT core: clear, fill, integrate, dump, hold for readout.
module msdft_sequencer
  import msdft_pkg::*;
#(
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned DFT_LEN = DftLenDefault,
  parameter int unsigned DROP_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [ACC_W-1:0]  cfg_acc_len_i,
  input  logic              cfg_continuous_i,
  input  logic              din_valid_i,
  output logic              core_rst_o,
  output logic              core_en_o,
  output logic              acc_dump_o,
  input  logic              core_res_valid_i,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic              busy_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam logic [ACC_W-1:0] FillTarget = ACC_W'(DFT_LEN);

  msdft_seq_state_t state_q, state_d;
  logic [ACC_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ACC_W-1:0] acc_len_q, acc_len_d, len_eff;
  logic             core_rst_q, core_en_q, acc_dump_q, dout_valid_q, busy_q;
  logic             acc_dump_d, drop_clr, drop_inc;

  assign cnt_inc = cnt_q + 1'b1;
  assign len_eff = (cfg_acc_len_i == '0) ? ACC_W'(1) : cfg_acc_len_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_len_d  = acc_len_q;
    acc_dump_d = 1'b0;
    drop_clr   = 1'b0;
    if (stop_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d  = StClr;
            drop_clr = 1'b1;
          end
        end
        StClr: begin
          state_d = StFill;
          cnt_d   = '0;
        end
        StFill: begin
          if (din_valid_i) begin
            if (cnt_inc == FillTarget) begin
              state_d   = StInteg;
              cnt_d     = '0;
              acc_len_d = len_eff;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        StInteg: begin
          if (din_valid_i) begin
            if (cnt_inc == acc_len_q) begin
              state_d    = StWaitRes;
              cnt_d      = '0;
              acc_dump_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        StWaitRes: begin
          if (core_res_valid_i) state_d = StHold;
        end
        StHold: begin
          // dout_valid is high throughout HOLD, so ready alone completes the handshake.
          if (dout_ready_i) begin
            if (cfg_continuous_i) begin
              state_d   = StInteg;
              cnt_d     = '0;
              acc_len_d = len_eff;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      acc_len_q    <= ACC_W'(1);
      core_rst_q   <= 1'b1;
      core_en_q    <= 1'b0;
      acc_dump_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_len_q    <= acc_len_d;
      core_rst_q   <= (state_d == StIdle) || (state_d == StClr);
      core_en_q    <= (state_d == StFill) || (state_d == StInteg) ||
                      (((state_d == StWaitRes) || (state_d == StHold)) && cfg_continuous_i);
      acc_dump_q   <= acc_dump_d;
      dout_valid_q <= (state_d == StHold);
      busy_q       <= (state_d != StIdle);
    end
  end

  // A sample is dropped when the core slides on it but no integration is running.
  assign drop_inc = din_valid_i && core_en_q && ((state_q == StWaitRes) || (state_q == StHold));

  msdft_sat_counter #(
    .Width(DROP_W)
  ) u_drop_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (drop_clr),
    .inc_i (drop_inc),
    .cnt_o (drop_cnt_o)
  );

  assign core_rst_o   = core_rst_q;
  assign core_en_o    = core_en_q;
  assign acc_dump_o   = acc_dump_q;
  assign dout_valid_o = dout_valid_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_msdft_sequencer.sv
// Self-checking bench: per-cycle reference model, latency table and directed corner cases.
module tb_msdft_sequencer;

  localparam int DFT_LEN = 64;
  localparam int PIdle = 0, PClr = 1, PFill = 2, PInteg = 3, PWait = 4, PHold = 5;

  logic        clk = 1'b0;
  logic        rst, start, stop, cont, din_valid, res_valid, dout_ready;
  logic [15:0] acc_len;
  logic        core_rst, core_en, acc_dump, dout_valid, busy;
  logic [15:0] drop16;
  logic        s_core_rst, s_core_en, s_acc_dump, s_dout_valid, s_busy;
  logic [3:0]  drop4;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase plus samples still needed in that phase.
  int m_ph = PIdle, m_left = 0, m_drop16 = 0, m_drop4 = 0;
  bit m_en = 0, m_dump = 0;

  always #5 clk = ~clk;

  msdft_sequencer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .cfg_acc_len_i(acc_len),
    .cfg_continuous_i(cont), .din_valid_i(din_valid), .core_rst_o(core_rst),
    .core_en_o(core_en), .acc_dump_o(acc_dump), .core_res_valid_i(res_valid),
    .dout_valid_o(dout_valid), .dout_ready_i(dout_ready), .busy_o(busy), .drop_cnt_o(drop16)
  );

  msdft_sequencer #(.DROP_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .cfg_acc_len_i(acc_len),
    .cfg_continuous_i(cont), .din_valid_i(din_valid), .core_rst_o(s_core_rst),
    .core_en_o(s_core_en), .acc_dump_o(s_acc_dump), .core_res_valid_i(res_valid),
    .dout_valid_o(s_dout_valid), .dout_ready_i(dout_ready), .busy_o(s_busy), .drop_cnt_o(drop4)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int eff_len();
    return (acc_len == 16'd0) ? 1 : int'(acc_len);
  endfunction

  task automatic model_step();
    bit sliding;
    sliding = ((m_ph == PWait) || (m_ph == PHold)) && m_en;
    m_dump = 0;
    if (rst) begin
      m_ph = PIdle; m_left = 0; m_drop16 = 0; m_drop4 = 0;
    end else begin
      if (sliding && din_valid) begin
        if (m_drop16 < 65535) m_drop16++;
        if (m_drop4 < 15) m_drop4++;
      end
      if (stop) m_ph = PIdle;
      else begin
        case (m_ph)
          PIdle: if (start) begin m_ph = PClr; m_drop16 = 0; m_drop4 = 0; end
          PClr: begin m_ph = PFill; m_left = DFT_LEN; end
          PFill: if (din_valid) begin
            m_left--;
            if (m_left == 0) begin m_ph = PInteg; m_left = eff_len(); end
          end
          PInteg: if (din_valid) begin
            m_left--;
            if (m_left == 0) begin m_ph = PWait; m_dump = 1; end
          end
          PWait: if (res_valid) m_ph = PHold;
          PHold: if (dout_ready) begin
            if (cont) begin m_ph = PInteg; m_left = eff_len(); end
            else m_ph = PIdle;
          end
          default: m_ph = PIdle;
        endcase
      end
    end
    m_en = !rst && ((m_ph == PFill) || (m_ph == PInteg) ||
                    (((m_ph == PWait) || (m_ph == PHold)) && cont));
  endtask

  task automatic check_all();
    chk("core_rst", {31'd0, core_rst}, int'(m_ph == PIdle || m_ph == PClr));
    chk("core_en", {31'd0, core_en}, int'(m_en));
    chk("acc_dump", {31'd0, acc_dump}, int'(m_dump));
    chk("dout_valid", {31'd0, dout_valid}, int'(m_ph == PHold));
    chk("busy", {31'd0, busy}, int'(m_ph != PIdle));
    chk("drop_cnt16", {16'd0, drop16}, m_drop16);
    chk("drop_cnt4", {28'd0, drop4}, m_drop4);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Edges from the start edge until acc_dump is seen (2000 if never).
  task automatic run_to_dump(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      lat++;
      if (acc_dump) break;
    end
  endtask

  // Result 3 cycles after the dump, ready held low 5 cycles then high.
  task automatic finish_single(input string tag);
    int n;
    tick(); tick();
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (dout_valid) n++;
      else if (n > 0) break;
      dout_ready = (n >= 6);
      tick();
    end
    dout_ready = 1'b0;
    chk({tag, "_dout_valid_cycles"}, 32'(n), 6);
    chk({tag, "_idle_after"}, {31'd0, busy}, 0);
  endtask

  typedef struct {
    int len;
    int exp_lat;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   lat, g, k;

    vecs[0] = '{len: 10, exp_lat: 75};
    vecs[1] = '{len: 0,  exp_lat: 66};
    vecs[2] = '{len: 1,  exp_lat: 66};
    vecs[3] = '{len: 4,  exp_lat: 69};
    vecs[4] = '{len: 3,  exp_lat: 68};

    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; din_valid = 1'b0;
    res_valid = 1'b0; dout_ready = 1'b0; acc_len = 16'd10;
    repeat (5) tick();
    chk("reset_core_rst", {31'd0, core_rst}, 1);
    chk("reset_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    tick();

    // Single-mode latency table, din_valid every cycle.
    din_valid = 1'b1;
    foreach (vecs[v]) begin
      acc_len = 16'(vecs[v].len);
      run_to_dump(lat);
      chk($sformatf("dump_latency_len%0d", vecs[v].len), 32'(lat), vecs[v].exp_lat);
      finish_single($sformatf("row%0d", v));
    end

    // Continuous mode: re-arm without refill, drops equal the WAIT/HOLD gap.
    cont = 1'b1; acc_len = 16'd4; dout_ready = 1'b1;
    run_to_dump(lat);
    chk("cont_first_dump", 32'(lat), 69);
    g = 1;
    tick(); g++;
    res_valid = 1'b1;
    tick(); g++;
    res_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!dout_valid) break;
      g++;
    end
    chk("cont_drop_eq_gap", {16'd0, drop16}, g);
    k = 3;
    for (int i = 0; i < 50; i++) begin
      tick(); k++;
      if (acc_dump) break;
    end
    chk("cont_second_dump_no_refill", 32'(k), 7);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("cont_stop_core_rst", {31'd0, core_rst}, 1);

    // Stop after 3 integration strobes, then a restart refills fully.
    cont = 1'b0; acc_len = 16'd10; dout_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (DFT_LEN + 4) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_core_rst", {31'd0, core_rst}, 1);
    chk("stop_busy", {31'd0, busy}, 0);
    chk("stop_no_dump", {31'd0, acc_dump}, 0);
    repeat (12) tick();
    run_to_dump(lat);
    chk("restart_refill_latency", 32'(lat), 75);
    finish_single("restart");

    // Start during FILL is ignored; zero length integrates one sample.
    acc_len = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    lat = 0;
    for (int i = 0; i < 2000; i++) begin
      start = (i == 10);
      tick(); lat++;
      if (acc_dump) break;
    end
    start = 1'b0;
    chk("start_in_fill_ignored", 32'(lat), 66);
    finish_single("len0");

    // Simultaneous start and stop in IDLE keeps the sequencer idle.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle_busy", {31'd0, busy}, 0);
    tick();
    chk("start_stop_idle_rst", {31'd0, core_rst}, 1);

    // Stalled readout in continuous mode saturates the narrow drop counter.
    cont = 1'b1; acc_len = 16'd2; dout_ready = 1'b0;
    run_to_dump(lat);
    tick(); res_valid = 1'b1; tick(); res_valid = 1'b0;
    repeat (22) tick();
    chk("drop4_saturated", {28'd0, drop4}, 15);
    stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("drop4_cleared_on_start", {28'd0, drop4}, 0);
    stop = 1'b1; tick(); stop = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      rst        = ($urandom_range(1499) == 0);
      stop       = ($urandom_range(399) == 0);
      start      = ($urandom_range(19) == 0);
      din_valid  = ($urandom_range(3) != 0);
      res_valid  = ($urandom_range(3) == 0);
      dout_ready = ($urandom_range(2) == 0);
      if ($urandom_range(49) == 0) cont = $urandom_range(1) != 0;
      if ($urandom_range(49) == 0) acc_len = 16'($urandom_range(5));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/msdft_sequencer.md
Name: msdft_sequencer

Overview:
- Run-time sequencer for the multiple sliding-DFT (MSDFT) datapath.
- Driven by start/stop strobes and configuration words from the msdft_control AXI-lite register bank.
- Resets the core, fills its DFT_LEN-sample delay line, integrates cfg_acc_len samples, commands an accumulator dump, then holds the result until the readout side accepts it.
- Optional continuous mode re-arms integration without refilling.

Parameters:
- ACC_W, 16, width of the integration length and the sample counter.
- DFT_LEN, 64, sliding-DFT window length; number of samples needed to fill the core delay line.
- DROP_W, 16, width of the saturating dropped-sample counter.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle strobe from the register bank; begins a run.
- stop  in  1  one-cycle strobe; aborts any run.
- cfg_acc_len  in  ACC_W  samples per integration; 0 is treated as 1.
- cfg_continuous  in  1  1 means re-arm after each readout.
- din_valid  in  1  ADC sample strobe.
- core_rst  out  1  clears the MSDFT core delay line and accumulators.
- core_en  out  1  gates din_valid into the core.
- acc_dump  out  1  one-cycle command to latch the core accumulators.
- core_res_valid  in  1  core result ready after acc_dump.
- dout_valid  out  1  result held for readout.
- dout_ready  in  1  readout accepts the result.
- busy  out  1  state is not IDLE.
- drop_cnt  out  DROP_W  saturating count of samples missed by integration.

Behaviour:
- Reset values: state=IDLE, core_rst=1, core_en=0, acc_dump=0, dout_valid=0, busy=0, drop_cnt=0, sample counter=0.
- All outputs are registered.
- IDLE:
  - core_rst=1, core_en=0.
  - start -> CLR, clear drop_cnt.
  - start in any other state is ignored.
- CLR: one cycle with core_rst=1, then -> FILL.
- FILL:
  - core_rst=0, core_en=1.
  - Count din_valid; on the DFT_LEN-th strobe, clear the counter and go to INTEG.
- INTEG:
  - core_en=1; count din_valid.
  - On the strobe that makes the count equal to max(cfg_acc_len,1), clear the counter, pulse acc_dump the next cycle, and go to WAIT_RES.
  - cfg_acc_len is sampled at INTEG entry; changes during INTEG take effect next integration.
- WAIT_RES:
  - Wait for core_res_valid; then set dout_valid=1 and go to HOLD.
  - core_res_valid outside WAIT_RES is ignored.
- HOLD:
  - dout_valid=1 until the cycle with dout_valid&dout_ready.
  - On that cycle: dout_valid drops next cycle.
  - cfg_continuous=1 -> INTEG, counter=0, no refill. cfg_continuous=0 -> IDLE.
  - dout_ready already high on HOLD entry completes the handshake in one cycle.
- Sliding and drops:
  - In continuous mode core_en stays 1 through WAIT_RES and HOLD, so the core keeps sliding.
  - Each din_valid in WAIT_RES/HOLD increments drop_cnt, saturating at all-ones.
  - In single mode core_en=0 in WAIT_RES/HOLD and no drops are counted.
- stop:
  - Any state -> IDLE next cycle; core_rst=1, dout_valid=0, acc_dump=0.
  - stop and start in the same cycle: stop wins.
- rst mid-run: identical to the reset values, regardless of state.

Decomposition:
- Shared package msdft_pkg:
  - State enum msdft_seq_state_t {IDLE, CLR, FILL, INTEG, WAIT_RES, HOLD}.
  - DFT_LEN default constant, shared with the MSDFT core.
- One natural sub-module, msdft_sat_counter: saturating DROP_W counter with synchronous clear.
- The sample counter stays inline.

Test Plan:
1. rst high 5 cycles -> core_rst=1, all other outputs 0. start, DFT_LEN=64, cfg_acc_len=10, din_valid every cycle -> acc_dump pulses once, 1 cycle after the 74th strobe.
2. core_res_valid 3 cycles after acc_dump, dout_ready low for 5 cycles then high -> dout_valid high exactly 6 cycles. cfg_continuous=0 -> busy=0 afterwards.
3. cfg_continuous=1, cfg_acc_len=4, din_valid every cycle, core_res_valid 2 cycles after dump, dout_ready tied high -> second acc_dump with no refill. drop_cnt counts the strobes seen in WAIT_RES/HOLD and equals the measured gap.
4. stop in INTEG after 3 strobes -> IDLE next cycle, core_rst=1, no acc_dump. Restart -> full refill of 64 samples before integration.
5. cfg_acc_len=0 -> integration of 1 sample. start during FILL -> ignored. Same-cycle start+stop in IDLE -> stays IDLE.
6. DROP_W=4, continuous mode, readout stalled for 20 strobes -> drop_cnt saturates at 15. Next start clears it to 0.
